// File: rtl/sgm_pkg.sv
// Shared definitions for the SGM disparity post-processing stages:
// disparity width, maximum row length and the hole-fill pipeline entry.
`timescale 1ns/1ps
package sgm_pkg;

  localparam int WIDTH_DISP = 9;
  localparam int MAX_WIDTH  = 1920;
  localparam int COL_W      = 11;

  // One in-flight pixel of the hole-fill shift register.
  typedef struct packed {
    logic [WIDTH_DISP-1:0] disp;    // raw disparity
    logic                  ok;      // trusted pixel
    logic                  valid;   // slot carries a pixel (0 = bubble)
    logic                  eol;     // last pixel of its row
    logic [WIDTH_DISP-1:0] r_val;   // nearest trusted right neighbour
    logic                  r_has;   // r_val is meaningful
    logic                  closed;  // a later row has started; no more capture
  } hf_entry_t;

  // Unsigned minimum of two disparities.
  function automatic logic [WIDTH_DISP-1:0] min_disp(
    input logic [WIDTH_DISP-1:0] a,
    input logic [WIDTH_DISP-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hole_fill_stage.sv
// One pipeline entry of the hole-fill shift register. While moving one
// stage down, the entry closes itself when a new row starts and otherwise
// captures the first trusted pixel that enters after it.
`timescale 1ns/1ps
module hole_fill_stage
  import sgm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  hf_entry_t             entry_i,
  input  logic                  in_valid,
  input  logic                  in_ok,
  input  logic                  in_col0,
  input  logic [WIDTH_DISP-1:0] in_disp,
  output hf_entry_t             entry_o
);

  hf_entry_t entry_d;
  hf_entry_t entry_q;

  // Close on a new row first, then capture against the updated closed flag.
  always_comb begin
    entry_d = entry_i;
    if (in_valid) begin
      if (in_col0) begin
        entry_d.closed = 1'b1;
      end
      if (in_ok && !entry_d.r_has && !entry_d.closed) begin
        entry_d.r_val = in_disp;
        entry_d.r_has = 1'b1;
      end
    end
  end

  // Entry register; bubbles and reset both leave valid=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
    end else if (clken) begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/disp_hole_fill_tx.sv
// Streaming hole filler. Untrusted pixels are replaced by the smaller of the
// last trusted value of the row (L) and the first trusted pixel that enters
// within DEPTH-1 cycles after the hole in the same row. Fixed DEPTH latency.
`timescale 1ns/1ps
module disp_hole_fill_tx
  import sgm_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WIDTH_DISP = sgm_pkg::WIDTH_DISP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  enable,
  input  logic [10:0]           width,
  input  logic                  valid_in,
  input  logic [WIDTH_DISP-1:0] disp_in,
  input  logic                  disp_ok,
  output logic [WIDTH_DISP-1:0] disp_hole,
  output logic                  valid_final_hole,
  output logic                  row_end
);

  localparam int CW = COL_W;

  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         width_q, width_d;
  logic                  at_col0;
  logic                  at_eol;
  hf_entry_t             new_entry;
  hf_entry_t             stage_ent [DEPTH];
  hf_entry_t             out_ent;
  logic [WIDTH_DISP-1:0] l_q, l_d;
  logic                  l_has_q, l_has_d;
  logic [WIDTH_DISP-1:0] fill_val;
  logic [WIDTH_DISP-1:0] disp_hole_q, disp_hole_d;
  logic                  valid_q, valid_d;
  logic                  row_end_q, row_end_d;
  logic                  unused_closed;

  // Column tracking; the row width is only re-sampled while at column 0.
  always_comb begin
    width_d = width_q;
    if (col_q == '0) begin
      width_d = (width > CW'(MAX_WIDTH)) ? CW'(MAX_WIDTH) : width;
    end
    at_col0 = (col_q == '0);
    at_eol  = (col_q == width_d - 11'd1);
    col_d   = col_q;
    if (valid_in) begin
      col_d = at_eol ? '0 : col_q + 11'd1;
    end
  end

  // Tag the entering pixel before it joins the shift register.
  always_comb begin
    new_entry       = '0;
    new_entry.disp  = disp_in;
    new_entry.ok    = disp_ok;
    new_entry.valid = valid_in;
    new_entry.eol   = valid_in & at_eol;
  end

  // Stage 0 only loads the new pixel; later stages see it as a neighbour.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    hf_entry_t stage_in;
    logic      stage_cap;
    if (gi == 0) begin : g_head
      assign stage_in  = new_entry;
      assign stage_cap = 1'b0;
    end else begin : g_tail
      assign stage_in  = stage_ent[gi-1];
      assign stage_cap = valid_in;
    end
    hole_fill_stage u_stage (
      .clk      (clk),
      .rst      (rst),
      .clken    (clken),
      .entry_i  (stage_in),
      .in_valid (stage_cap),
      .in_ok    (disp_ok),
      .in_col0  (at_col0),
      .in_disp  (disp_in),
      .entry_o  (stage_ent[gi])
    );
  end

  assign out_ent       = stage_ent[DEPTH-1];
  assign unused_closed = out_ent.closed;

  // Output mux and left-value bookkeeping for the departing entry.
  always_comb begin
    fill_val = '0;
    if (out_ent.ok || !enable) begin
      fill_val = out_ent.disp;
    end else if (l_has_q && out_ent.r_has) begin
      fill_val = min_disp(l_q, out_ent.r_val);
    end else if (l_has_q) begin
      fill_val = l_q;
    end else if (out_ent.r_has) begin
      fill_val = out_ent.r_val;
    end

    valid_d     = out_ent.valid;
    row_end_d   = out_ent.valid & out_ent.eol;
    disp_hole_d = out_ent.valid ? fill_val : '0;

    l_d     = l_q;
    l_has_d = l_has_q;
    if (out_ent.valid) begin
      if (out_ent.ok) begin
        l_d     = out_ent.disp;
        l_has_d = 1'b1;
      end
      if (out_ent.eol) begin
        l_has_d = 1'b0;
      end
    end
  end

  // Column counter, left value and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      width_q     <= '0;
      l_q         <= '0;
      l_has_q     <= 1'b0;
      disp_hole_q <= '0;
      valid_q     <= 1'b0;
      row_end_q   <= 1'b0;
    end else if (clken) begin
      col_q       <= col_d;
      width_q     <= width_d;
      l_q         <= l_d;
      l_has_q     <= l_has_d;
      disp_hole_q <= disp_hole_d;
      valid_q     <= valid_d;
      row_end_q   <= row_end_d;
    end
  end

  assign disp_hole        = disp_hole_q;
  assign valid_final_hole = valid_q;
  assign row_end          = row_end_q;

endmodule

// File: tb/tb_disp_hole_fill_tx.sv
// Bench for disp_hole_fill_tx: per-cycle comparison against a row-level
// model plus literal expectations for each directed row.
`timescale 1ns/1ps
module tb_disp_hole_fill_tx;

  localparam int D  = 4;
  localparam int NH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clken = 1'b1;
  logic        enable = 1'b1;
  logic [10:0] width = 11'd8;
  logic        valid_in = 1'b0;
  logic [8:0]  disp_in = '0;
  logic        disp_ok = 1'b0;
  logic [8:0]  disp_hole;
  logic        valid_final_hole;
  logic        row_end;

  always #5 clk = ~clk;

  disp_hole_fill_tx #(.DEPTH(D), .WIDTH_DISP(9)) dut (
    .clk              (clk),
    .rst              (rst),
    .clken            (clken),
    .enable           (enable),
    .width            (width),
    .valid_in         (valid_in),
    .disp_in          (disp_in),
    .disp_ok          (disp_ok),
    .disp_hole        (disp_hole),
    .valid_final_hole (valid_final_hole),
    .row_end          (row_end)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- model: history of accepted input slots ----------------
  logic [8:0] h_disp [NH];
  bit         h_valid [NH];
  bit         h_ok [NH];
  bit         h_eol [NH];
  int         h_row [NH];
  int         ecnt = 0, gedge = 0, m_col = 0, m_w = 8, m_row = 0;
  bit         exp_v = 0, exp_e = 0, adv = 0;
  logic [8:0] exp_d = '0;

  // Expected output for slot k, from the row's trusted pixels around it.
  function automatic void predict(int k);
    bit lh, rh;
    int lv, rv;
    exp_v = 0; exp_e = 0; exp_d = '0;
    if (k >= 0 && h_valid[k]) begin
      exp_v = 1;
      exp_e = h_eol[k];
      if (h_ok[k] || !enable) begin
        exp_d = h_disp[k];
      end else begin
        lh = 0; rh = 0; lv = 0; rv = 0;
        for (int j = k - 1; j >= 0; j--) begin
          if (h_valid[j]) begin
            if (h_row[j] != h_row[k]) break;
            if (h_ok[j]) begin lh = 1; lv = int'(h_disp[j]); break; end
          end
        end
        for (int j = k + 1; j <= k + D - 1; j++) begin
          if (h_valid[j]) begin
            if (h_row[j] != h_row[k]) break;
            if (h_ok[j]) begin rh = 1; rv = int'(h_disp[j]); break; end
          end
        end
        if (lh && rh)  exp_d = 9'((lv < rv) ? lv : rv);
        else if (lh)   exp_d = 9'(lv);
        else if (rh)   exp_d = 9'(rv);
        else           exp_d = '0;
      end
    end
  endfunction

  always @(posedge clk) begin
    adv = 0;
    if (!rst) begin
      ecnt = 0; m_col = 0; m_row = 0;
      exp_v = 0; exp_e = 0; exp_d = '0;
    end else if (clken && ecnt < NH) begin
      adv = 1;
      gedge++;
      h_valid[ecnt] = valid_in;
      h_disp[ecnt]  = disp_in;
      h_ok[ecnt]    = disp_ok;
      h_eol[ecnt]   = 0;
      h_row[ecnt]   = m_row;
      if (valid_in) begin
        if (m_col == 0) m_w = int'(width);
        if (m_col == m_w - 1) begin
          h_eol[ecnt] = 1; m_col = 0; m_row++;
        end else begin
          m_col++;
        end
      end
      ecnt++;
      predict(ecnt - 1 - D);
    end
  end

  // ---------------- compare process + output collection ----------------
  int outs_q[$];
  int ends_q[$];
  int edges_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", int'(valid_final_hole), 0);
      chk("rst_row_end", int'(row_end), 0);
      chk("rst_disp", int'(disp_hole), 0);
    end else begin
      chk("valid", int'(valid_final_hole), int'(exp_v));
      chk("row_end", int'(row_end), int'(exp_e));
      if (exp_v) chk("disp", int'(disp_hole), int'(exp_d));
      if (adv && valid_final_hole) begin
        outs_q.push_back(int'(disp_hole));
        ends_q.push_back(int'(row_end));
        edges_q.push_back(gedge);
      end
    end
  end

  // ---------------- driver ----------------
  int first_in_edge = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      clken = 1; valid_in = 0; disp_in = '0; disp_ok = 0;
    end
  endtask

  task automatic send_row(input int d[8], input bit [7:0] okm, input int n, input int freeze_at);
    for (int i = 0; i < n; i++) begin
      if (i == freeze_at) begin
        for (int f = 0; f < 3; f++) begin
          tick();
          clken = 0; valid_in = 1; disp_in = 9'd255; disp_ok = 1;
        end
      end
      tick();
      clken = 1; valid_in = 1; disp_in = 9'(d[i]); disp_ok = okm[i];
      if (i == 0) first_in_edge = gedge + 1;
    end
  endtask

  task automatic check8(input string nm, input int e[8], input int base);
    int a;
    int en;
    for (int i = 0; i < 8; i++) begin
      a  = (base + i < outs_q.size()) ? outs_q[base + i] : -1;
      en = (base + i < ends_q.size()) ? ends_q[base + i] : -1;
      chk($sformatf("%s_val[%0d]", nm, i), a, e[i]);
      chk($sformatf("%s_end[%0d]", nm, i), en, (i == 7) ? 1 : 0);
    end
  endtask

  task automatic clear_outs();
    outs_q.delete(); ends_q.delete(); edges_q.delete();
  endtask

  initial begin
    int dv[8];
    int ev[8];
    repeat (3) @(posedge clk);
    #2 rst = 1;
    idle(2);

    // No holes: values pass unchanged, 4-cycle latency, row_end on 17.
    dv = '{10, 11, 12, 13, 14, 15, 16, 17};
    send_row(dv, 8'hFF, 8, -1);
    idle(D + 3);
    ev = '{10, 11, 12, 13, 14, 15, 16, 17};
    check8("nohole", ev, 0);
    chk("nohole_count", outs_q.size(), 8);
    chk("latency", (edges_q.size() > 0) ? edges_q[0] - first_in_edge : -1, D);
    clear_outs();

    // Interior runs: min(L, R).
    dv = '{20, 99, 99, 12, 5, 99, 99, 30};
    send_row(dv, 8'b10011001, 8, -1);
    idle(D + 3);
    ev = '{20, 12, 12, 12, 5, 5, 5, 30};
    check8("interior", ev, 0);
    clear_outs();

    // Holes at row start: right neighbour only.
    dv = '{99, 99, 30, 31, 32, 33, 34, 35};
    send_row(dv, 8'b11111100, 8, -1);
    idle(D + 3);
    ev = '{30, 30, 30, 31, 32, 33, 34, 35};
    check8("rowstart", ev, 0);
    clear_outs();

    // Window overflow: only the last three holes see the 5.
    dv = '{9, 99, 99, 99, 99, 99, 99, 5};
    send_row(dv, 8'b10000001, 8, -1);
    idle(D + 3);
    ev = '{9, 9, 9, 9, 5, 5, 5, 5};
    check8("window", ev, 0);
    clear_outs();

    // Row boundary: trailing holes must not take the next row's 40.
    dv = '{1, 2, 3, 4, 5, 7, 99, 99};
    send_row(dv, 8'b00111111, 8, -1);
    dv = '{40, 41, 42, 43, 44, 45, 46, 47};
    send_row(dv, 8'hFF, 8, -1);
    idle(D + 3);
    ev = '{1, 2, 3, 4, 5, 7, 7, 7};
    check8("bound_r0", ev, 0);
    ev = '{40, 41, 42, 43, 44, 45, 46, 47};
    check8("bound_r1", ev, 8);
    chk("bound_count", outs_q.size(), 16);
    clear_outs();

    // enable=0: raw disparity through, same latency.
    enable = 0;
    dv = '{50, 60, 61, 52, 53, 54, 55, 56};
    send_row(dv, 8'b11111001, 8, -1);
    idle(D + 3);
    ev = '{50, 60, 61, 52, 53, 54, 55, 56};
    check8("bypass", ev, 0);
    chk("bypass_latency", (edges_q.size() > 0) ? edges_q[0] - first_in_edge : -1, D);
    enable = 1;
    clear_outs();

    // clken low for 3 cycles mid-row while outputs are live.
    dv = '{70, 71, 72, 73, 99, 60, 76, 77};
    send_row(dv, 8'b11101111, 8, 5);
    idle(D + 3);
    ev = '{70, 71, 72, 73, 60, 60, 76, 77};
    check8("freeze", ev, 0);
    chk("freeze_count", outs_q.size(), 8);
    clear_outs();

    // Reset mid-row: outputs drop at once, next row starts at column 0.
    dv = '{80, 81, 82, 83, 84, 85, 86, 87};
    send_row(dv, 8'hFF, 5, -1);
    tick();
    rst = 0; valid_in = 0;
    #1;
    chk("midrst_valid", int'(valid_final_hole), 0);
    chk("midrst_disp", int'(disp_hole), 0);
    chk("midrst_row_end", int'(row_end), 0);
    tick();
    tick();
    rst = 1;
    clear_outs();
    dv = '{90, 91, 92, 93, 94, 95, 96, 97};
    send_row(dv, 8'hFF, 8, -1);
    idle(D + 3);
    ev = '{90, 91, 92, 93, 94, 95, 96, 97};
    check8("after_rst", ev, 0);
    chk("after_rst_count", outs_q.size(), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
